// File: rtl/nport_mem_arbiter_pkg.sv
// Shared arbiter types: transaction FSM states and grant-mode constants.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_e;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/nport_mem_arbiter_sel.sv
// Grant selection: round-robin search starting after the last granted port,
// or fixed priority with port 0 highest.
module rr_priority_select
  import lc3b_types::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last,
  input  logic                 i_mode,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_valid
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      // Candidate i-th in search order; first requesting candidate wins.
      if (i_mode == ARB_RR) begin
        w_cand = IDX_W'((32'(i_last) + 32'd1 + i) % NUM_PORTS);
      end else begin
        w_cand = IDX_W'(i);
      end
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nport_mem_arbiter.sv
// N-port cache line arbiter in front of a single physical memory port.
// One transaction at a time: IDLE (arbitrate/latch) -> ACCESS -> DONE.
module nport_mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned RR_MODE    = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             cli_read,
  input  logic [NUM_PORTS-1:0]             cli_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  cli_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  cli_wdata,
  output logic [NUM_PORTS-1:0]             cli_resp,
  output logic [LINE_WIDTH-1:0]            cli_rdata,
  output logic                             pmem_read,
  output logic                             pmem_write,
  output logic [ADDR_WIDTH-1:0]            pmem_address,
  output logic [LINE_WIDTH-1:0]            pmem_wdata,
  input  logic                             pmem_resp,
  input  logic [LINE_WIDTH-1:0]            pmem_rdata,
  output logic [$clog2(NUM_PORTS)-1:0]     grant_id,
  output logic                             busy
);

  localparam int unsigned IDX_W    = $clog2(NUM_PORTS);
  localparam logic        ARB_MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  arb_state_e             r_state;
  arb_state_e             w_next;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       r_last;
  logic [NUM_PORTS-1:0]   r_grant;
  logic                   r_write;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [LINE_WIDTH-1:0]  r_wdata;

  logic [NUM_PORTS-1:0]   w_req;
  logic [NUM_PORTS-1:0]   w_grant;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_valid;

  assign w_req = cli_read | cli_write;

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_sel (
    .i_req   (w_req),
    .i_last  (r_last),
    .i_mode  (ARB_MODE),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Transaction is captured once in IDLE so the memory side never sees
  // client-side changes made while the access is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx   <= '0;
      r_last  <= IDX_W'(NUM_PORTS - 1);
      r_grant <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE && w_valid) begin
      r_idx   <= w_idx;
      r_last  <= w_idx;
      r_grant <= w_grant;
      r_write <= cli_write[w_idx];
      r_addr  <= cli_address[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
      r_wdata <= cli_wdata[w_idx*LINE_WIDTH +: LINE_WIDTH];
    end
  end

  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    grant_id   = '0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    cli_resp   = '0;
    unique case (r_state)
      IDLE: begin
        if (w_valid) w_next = ACCESS;
      end
      ACCESS: begin
        busy       = 1'b1;
        grant_id   = r_idx;
        pmem_read  = ~r_write;
        pmem_write = r_write;
        if (pmem_resp) begin
          w_next = DONE;
          // An access abandoned by reset must not complete to the client.
          if (!reset) cli_resp = r_grant;
        end
      end
      DONE: begin
        busy     = 1'b1;
        grant_id = r_idx;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign cli_rdata    = pmem_rdata;

endmodule

// File: tb/tb_nport_mem_arbiter.sv
// Directed bench for nport_mem_arbiter: 2-port round-robin, 2-port fixed
// priority and 4-port round-robin instances, each with a simple memory model.
module tb_nport_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 2 ports, round-robin
  logic         a_reset = 1'b1;
  logic [1:0]   a_read = '0, a_write = '0;
  logic [31:0]  a_addr = '0;
  logic [255:0] a_wdata = '0;
  logic [1:0]   a_cresp;
  logic [127:0] a_crdata;
  logic         a_pr, a_pw;
  logic [15:0]  a_paddr;
  logic [127:0] a_pwdata;
  logic         a_presp = 1'b0, a_force = 1'b0;
  logic [127:0] a_prdata = '0;
  logic         a_gid, a_busy;
  int           a_lat = 1, a_cnt = 0;

  // Instance B: 2 ports, fixed priority
  logic         b_reset = 1'b1;
  logic [1:0]   b_read = '0, b_write = '0;
  logic [31:0]  b_addr = '0;
  logic [255:0] b_wdata = '0;
  logic [1:0]   b_cresp;
  logic [127:0] b_crdata;
  logic         b_pr, b_pw;
  logic [15:0]  b_paddr;
  logic [127:0] b_pwdata;
  logic         b_presp = 1'b0;
  logic [127:0] b_prdata = '0;
  logic         b_gid, b_busy;
  int           b_lat = 1, b_cnt = 0;

  // Instance C: 4 ports, round-robin
  logic         c_reset = 1'b1;
  logic [3:0]   c_read = '0, c_write = '0;
  logic [63:0]  c_addr = '0;
  logic [511:0] c_wdata = '0;
  logic [3:0]   c_cresp;
  logic [127:0] c_crdata;
  logic         c_pr, c_pw;
  logic [15:0]  c_paddr;
  logic [127:0] c_pwdata;
  logic         c_presp = 1'b0;
  logic [127:0] c_prdata = '0;
  logic [1:0]   c_gid;
  logic         c_busy;
  int           c_lat = 1, c_cnt = 0;

  nport_mem_arbiter #(.NUM_PORTS(2), .LINE_WIDTH(128), .ADDR_WIDTH(16), .RR_MODE(1)) u_a (
    .clk(clk), .reset(a_reset), .cli_read(a_read), .cli_write(a_write),
    .cli_address(a_addr), .cli_wdata(a_wdata), .cli_resp(a_cresp), .cli_rdata(a_crdata),
    .pmem_read(a_pr), .pmem_write(a_pw), .pmem_address(a_paddr), .pmem_wdata(a_pwdata),
    .pmem_resp(a_presp | a_force), .pmem_rdata(a_prdata), .grant_id(a_gid), .busy(a_busy)
  );

  nport_mem_arbiter #(.NUM_PORTS(2), .LINE_WIDTH(128), .ADDR_WIDTH(16), .RR_MODE(0)) u_b (
    .clk(clk), .reset(b_reset), .cli_read(b_read), .cli_write(b_write),
    .cli_address(b_addr), .cli_wdata(b_wdata), .cli_resp(b_cresp), .cli_rdata(b_crdata),
    .pmem_read(b_pr), .pmem_write(b_pw), .pmem_address(b_paddr), .pmem_wdata(b_pwdata),
    .pmem_resp(b_presp), .pmem_rdata(b_prdata), .grant_id(b_gid), .busy(b_busy)
  );

  nport_mem_arbiter #(.NUM_PORTS(4), .LINE_WIDTH(128), .ADDR_WIDTH(16), .RR_MODE(1)) u_c (
    .clk(clk), .reset(c_reset), .cli_read(c_read), .cli_write(c_write),
    .cli_address(c_addr), .cli_wdata(c_wdata), .cli_resp(c_cresp), .cli_rdata(c_crdata),
    .pmem_read(c_pr), .pmem_write(c_pw), .pmem_address(c_paddr), .pmem_wdata(c_pwdata),
    .pmem_resp(c_presp), .pmem_rdata(c_prdata), .grant_id(c_gid), .busy(c_busy)
  );

  // Memory models: respond on the lat-th cycle a strobe has been seen high.
  always @(posedge clk) begin
    #2;
    if (a_pr | a_pw) begin a_cnt++; a_presp = (a_cnt == a_lat); end
    else begin a_cnt = 0; a_presp = 1'b0; end
  end
  always @(posedge clk) begin
    #2;
    if (b_pr | b_pw) begin b_cnt++; b_presp = (b_cnt == b_lat); end
    else begin b_cnt = 0; b_presp = 1'b0; end
  end
  always @(posedge clk) begin
    #2;
    if (c_pr | c_pw) begin c_cnt++; c_presp = (c_cnt == c_lat); end
    else begin c_cnt = 0; c_presp = 1'b0; end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Each wait returns the responding port, 98 for a non-one-hot response,
  // 99 if no response arrives within the cycle budget.
  task automatic wait_a(output int idx);
    idx = 99;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (a_cresp != 2'b00) begin
        idx = (a_cresp == 2'b01) ? 0 : (a_cresp == 2'b10) ? 1 : 98;
        break;
      end
    end
  endtask

  task automatic wait_b(output int idx);
    idx = 99;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (b_cresp != 2'b00) begin
        idx = (b_cresp == 2'b01) ? 0 : (b_cresp == 2'b10) ? 1 : 98;
        break;
      end
    end
  endtask

  task automatic wait_c(output int idx);
    idx = 99;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (c_cresp != 4'b0000) begin
        case (c_cresp)
          4'b0001: idx = 0;
          4'b0010: idx = 1;
          4'b0100: idx = 2;
          4'b1000: idx = 3;
          default: idx = 98;
        endcase
        break;
      end
    end
  endtask

  initial begin
    int g;
    int exp_a[4] = '{0, 1, 0, 1};
    int exp_c[5] = '{0, 1, 2, 3, 0};

    tick(); tick();
    a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
    tick();
    chk("rst_pmem_read",  a_pr, 0);
    chk("rst_pmem_write", a_pw, 0);
    chk("rst_pmem_addr",  a_paddr, 0);
    chk("rst_pmem_wdata", a_pwdata, 0);
    chk("rst_cli_resp",   a_cresp, 0);
    chk("rst_busy",       a_busy, 0);
    chk("rst_grant_id",   a_gid, 0);
    chk("rst_c_busy",     c_busy, 0);

    // Single read from port 1, memory latency 3
    a_lat = 3; a_prdata = {16{8'hA5}};
    a_addr[31:16] = 16'h1230; a_read = 2'b10;
    tick();
    chk("rd_c1_pmem_read", a_pr, 1);
    chk("rd_c1_addr",      a_paddr, 16'h1230);
    chk("rd_c1_busy",      a_busy, 1);
    chk("rd_c1_grant",     a_gid, 1);
    chk("rd_c1_resp",      a_cresp, 0);
    tick();
    chk("rd_c2_pmem_read", a_pr, 1);
    chk("rd_c2_resp",      a_cresp, 0);
    tick();
    chk("rd_c3_pmem_read", a_pr, 1);
    chk("rd_c3_resp",      a_cresp, 2'b10);
    chk("rd_c3_rdata",     a_crdata, {16{8'hA5}});
    a_read = 2'b00;
    tick();
    chk("rd_done_pmem_read", a_pr, 0);
    chk("rd_done_resp",      a_cresp, 0);
    chk("rd_done_busy",      a_busy, 1);
    chk("rd_done_grant",     a_gid, 1);
    tick();
    chk("rd_idle_busy",  a_busy, 0);
    chk("rd_idle_grant", a_gid, 0);

    // Reset during a pending read, then a stray pmem_resp in IDLE
    a_lat = 100; a_addr[15:0] = 16'h0222; a_read = 2'b01;
    tick();
    chk("rst_mid_pmem_read_before", a_pr, 1);
    chk("rst_mid_busy_before",      a_busy, 1);
    a_reset = 1'b1; a_read = 2'b00;
    tick();
    chk("rst_mid_pmem_read", a_pr, 0);
    chk("rst_mid_busy",      a_busy, 0);
    chk("rst_mid_resp",      a_cresp, 0);
    a_reset = 1'b0; a_force = 1'b1;
    tick();
    chk("stray_resp_cli_resp", a_cresp, 0);
    chk("stray_resp_busy",     a_busy, 0);
    a_force = 1'b0;

    // Write from port 0; client changes address/data mid-access
    a_lat = 3; a_addr[15:0] = 16'h0040; a_wdata[127:0] = {8{16'h1111}}; a_write = 2'b01;
    tick();
    chk("wr_c1_pmem_write", a_pw, 1);
    chk("wr_c1_pmem_read",  a_pr, 0);
    chk("wr_c1_addr",       a_paddr, 16'h0040);
    chk("wr_c1_wdata",      a_pwdata, {8{16'h1111}});
    a_addr[15:0] = 16'hFFFF; a_wdata[127:0] = '0;
    tick();
    chk("wr_c2_addr",  a_paddr, 16'h0040);
    chk("wr_c2_wdata", a_pwdata, {8{16'h1111}});
    tick();
    chk("wr_c3_resp",  a_cresp, 2'b01);
    chk("wr_c3_addr",  a_paddr, 16'h0040);
    chk("wr_c3_wdata", a_pwdata, {8{16'h1111}});
    a_write = 2'b00;
    tick();
    chk("wr_done_pmem_write", a_pw, 0);
    tick();

    // Round-robin alternation with both ports reading continuously
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0; a_lat = 1; a_read = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_a(g);
      chk($sformatf("rr2_grant%0d", i), g, exp_a[i]);
    end
    a_read = 2'b00;

    // Fixed priority: port 0 always wins
    b_read = 2'b11;
    for (int i = 0; i < 3; i++) begin
      wait_b(g);
      chk($sformatf("fixed_grant%0d", i), g, 0);
    end
    b_read = 2'b00;

    // Four ports all requesting: rotation with wrap
    c_read = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_c(g);
      chk($sformatf("rr4_grant%0d", i), g, exp_c[i]);
    end
    c_read = 4'h0;
    tick(); tick();

    // Read+write on port 2 is a write
    c_addr[47:32] = 16'h0BEE; c_read = 4'b0100; c_write = 4'b0100;
    tick();
    chk("rw_pmem_write", c_pw, 1);
    chk("rw_pmem_read",  c_pr, 0);
    chk("rw_grant",      c_gid, 2);
    chk("rw_addr",       c_paddr, 16'h0BEE);
    chk("rw_resp",       c_cresp, 4'b0100);
    c_read = 4'h0; c_write = 4'h0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nport_mem_arbiter.md
NPORT_MEM_ARBITER -- requirements
Module: nport_mem_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of client caches (legal 2..8).
REQ-002 Parameter LINE_WIDTH, default 128: cache line width in bits.
REQ-003 Parameter ADDR_WIDTH, default 16: physical address width.
REQ-004 Parameter RR_MODE, default 1: 1 = round-robin grant; 0 = fixed priority, port 0 highest.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  system clock, all state on posedge.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 cli_read  in  NUM_PORTS  per-port line read request.
REQ-009 cli_write  in  NUM_PORTS  per-port line write request.
REQ-010 cli_address  in  NUM_PORTS x ADDR_WIDTH  per-port line address.
REQ-011 cli_wdata  in  NUM_PORTS x LINE_WIDTH  per-port write line.
REQ-012 cli_resp  out  NUM_PORTS  per-port one-cycle completion pulse.
REQ-013 cli_rdata  out  LINE_WIDTH  read line, broadcast to all ports, valid with cli_resp.
REQ-014 pmem_read / pmem_write  out  1 each  physical memory request strobes.
REQ-015 pmem_address  out  ADDR_WIDTH; pmem_wdata  out  LINE_WIDTH.
REQ-016 pmem_resp  in  1; pmem_rdata  in  LINE_WIDTH  physical memory completion and data.
REQ-017 grant_id  out  clog2(NUM_PORTS)  index of port currently served; busy  out  1  transaction in flight.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-019 IDLE: when any port has cli_read|cli_write, select one port per mode, latch its index, op, address, wdata; go to ACCESS next cycle.
REQ-020 Round-robin: search starts at (last granted + 1) mod NUM_PORTS, wrapping; last granted initialises to NUM_PORTS-1 so port 0 wins first.
REQ-021 Fixed mode: lowest-index requesting port wins.
REQ-022 Port asserting both read and write SHALL be treated as a write.
REQ-023 ACCESS: pmem_read or pmem_write driven from latched op; pmem_address/pmem_wdata from latched registers, stable for whole transaction regardless of client input changes.
REQ-024 ACCESS with pmem_resp=1: assert cli_resp[grant] for that cycle only, pass pmem_rdata to cli_rdata combinationally, deassert pmem strobes next cycle, go to DONE.
REQ-025 DONE: one idle cycle (no grant, no pmem strobe) so the served client deasserts its request; then IDLE.
REQ-026 Minimum latency request-to-cli_resp: 2 cycles plus memory latency; back-to-back transactions separated by at least 2 cycles without pmem strobes.
REQ-027 Requests arriving during ACCESS/DONE SHALL wait; no request is dropped while held high.
REQ-028 Round-robin SHALL bound wait of a held request to NUM_PORTS-1 other transactions.
REQ-029 cli_resp SHALL never assert for a non-granted port; at most one bit set per cycle.
REQ-030 busy = 1 in ACCESS and DONE; grant_id holds latched index in ACCESS/DONE, 0 in IDLE.
REQ-031 pmem_resp outside ACCESS SHALL be ignored.

Reset
REQ-032 reset SHALL return FSM to IDLE in the next cycle from any state, including mid-ACCESS (in-flight transaction abandoned, no cli_resp).
REQ-033 Reset values: pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, cli_resp=0, busy=0, grant_id=0, last-granted pointer=NUM_PORTS-1.

Structure
REQ-034 Arbiter state enum and mode constants (ARB_FIXED, ARB_RR) SHALL live in the shared lc3b_types package.
REQ-035 Grant selection SHALL be a sub-module rr_priority_select (inputs request vector, last pointer, mode; output one-hot grant and index).

Verification
REQ-036 Single read: port1 reads 0x1230, memory responds after 3 cycles with 0xA5..A5 -> pmem_read 1 for 3 cycles, address 0x1230, cli_resp[1] one pulse, cli_rdata=0xA5..A5.
REQ-037 Simultaneous: ports 0 and 1 read continuously, RR_MODE=1 -> grants alternate 0,1,0,1; RR_MODE=0 -> port 0 always granted.
REQ-038 Write stability: port0 writes 0x0040 data 0x1111.., changes cli_address to 0xFFFF during ACCESS -> pmem_address remains 0x0040, pmem_wdata unchanged until pmem_resp.
REQ-039 Reset mid-ACCESS: assert reset during pending read -> next cycle pmem_read=0, busy=0, no cli_resp; later pmem_resp ignored.
REQ-040 NUM_PORTS=4, all request -> grants 0,1,2,3,0 with wrap; read+write on port 2 issues pmem_write.
